// File: rtl/aes_round_counter_if.sv
// ----------------------------------------------------------------------------
// aes_round_counter_if
//
// Purpose: bundles the control handshake and the status/Rcon outputs of the
//          AES round sequencer so the control FSM and the sequencer share one
//          port object.
//
// Signals:
//   start     master->slave  1  begin (or restart) an operation
//   advance   master->slave  1  step to the next round
//   key_len   master->slave  2  00=AES-128, 01=AES-192, 10=AES-256, 11=AES-128
//   round     slave->master  4  current round index, 0..Nr
//   is_final  slave->master  1  busy and round == Nr
//   done      slave->master  1  operation complete (level)
//   busy      slave->master  1  sequence in progress
//   rcon      slave->master  8  key-expansion round constant for this round
//
// Modports:
//   master : the AES control FSM side (drives start/advance/key_len)
//   slave  : the round counter itself
// ----------------------------------------------------------------------------
interface aes_round_counter_if;
  logic       start;
  logic       advance;
  logic [1:0] key_len;
  logic [3:0] round;
  logic       is_final;
  logic       done;
  logic       busy;
  logic [7:0] rcon;

  modport master (
    output start,
    output advance,
    output key_len,
    input  round,
    input  is_final,
    input  done,
    input  busy,
    input  rcon
  );

  modport slave (
    input  start,
    input  advance,
    input  key_len,
    output round,
    output is_final,
    output done,
    output busy,
    output rcon
  );
endinterface

// File: rtl/aes_round_counter.sv
// ----------------------------------------------------------------------------
// aes_round_counter
//
// Purpose: round sequencer for the AES datapath. A start pulse latches the key
//          length (Nr = 10/12/14), then each advance pulse steps the round
//          index from 0 up to Nr. One advance past the final round ends the
//          sequence and raises done. Optionally produces the key-expansion
//          round constant (Rcon) for the current round.
//
// Ports:
//   clk    in   rising-edge system clock
//   rst_n  in   asynchronous active-low reset
//   ctl    slave modport of aes_round_counter_if:
//            start, advance, key_len in; round, is_final, done, busy, rcon out
//
// Configuration macro:
//   AES_RCON_EN  defined   -> Rcon register and xtime logic are built
//                undefined -> rcon is tied to 8'h00, everything else identical
// ----------------------------------------------------------------------------
module aes_round_counter (
  input  logic               clk,
  input  logic               rst_n,
  aes_round_counter_if.slave ctl
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [3:0] r_round;
  logic [3:0] r_nr;
  logic [3:0] w_nr_sel;
  logic       w_at_final;
  logic       w_step;

  // --------------------------------------------------------------------------
  // Key-length decode. The reserved code 11 falls back to AES-128.
  // --------------------------------------------------------------------------
  always_comb begin
    w_nr_sel = 4'd10;
    case (ctl.key_len)
      2'b01:   w_nr_sel = 4'd12;
      2'b10:   w_nr_sel = 4'd14;
      default: w_nr_sel = 4'd10;
    endcase
  end

  assign w_at_final = (r_round == r_nr);

  // An advance only moves the counter while running and below Nr; start
  // always has priority, so a simultaneous advance is dropped.
  assign w_step = ctl.advance && !ctl.start && (r_state == ST_RUN) && !w_at_final;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (ctl.start) begin
      // Accepted from every state; a start while running restarts the sequence.
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_IDLE;
        ST_RUN: begin
          if (ctl.advance && w_at_final) begin
            w_state_next = ST_DONE;
          end
        end
        ST_DONE: w_state_next = ST_DONE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. All decoded from registered state, so they only move on a
  // clock edge (or on reset).
  // --------------------------------------------------------------------------
  always_comb begin
    ctl.busy     = 1'b0;
    ctl.done     = 1'b0;
    ctl.is_final = 1'b0;
    case (r_state)
      ST_RUN: begin
        ctl.busy     = 1'b1;
        ctl.is_final = w_at_final;
      end
      ST_DONE: begin
        ctl.done = 1'b1;
      end
      default: begin
        ctl.busy     = 1'b0;
        ctl.done     = 1'b0;
        ctl.is_final = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Nr latch: captured only when start is accepted, so key_len may change
  // freely during a run without affecting the sequence.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nr <= 4'd10;
    end else if (ctl.start) begin
      r_nr <= w_nr_sel;
    end
  end

  // --------------------------------------------------------------------------
  // Round counter. Saturates at Nr: the advance that ends the run leaves the
  // index at Nr, so it never wraps.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= 4'd0;
    end else if (ctl.start) begin
      r_round <= 4'd0;
    end else if (w_step) begin
      r_round <= r_round + 4'd1;
    end
  end

  assign ctl.round = r_round;

  // --------------------------------------------------------------------------
  // Round constant
  // --------------------------------------------------------------------------
`ifdef AES_RCON_EN
  logic [7:0] r_rcon;
  logic [7:0] w_xtime;

  // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
  assign w_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcon <= 8'h00;
    end else if (ctl.start) begin
      r_rcon <= 8'h00;
    end else if (w_step) begin
      // Round 0 holds 00, so seed the chain with 01 instead of doubling.
      if (r_round == 4'd0) begin
        r_rcon <= 8'h01;
      end else begin
        r_rcon <= w_xtime;
      end
    end
  end

  assign ctl.rcon = r_rcon;
`else
  assign ctl.rcon = 8'h00;
`endif

endmodule

// File: tb/tb_aes_round_counter.sv
// ----------------------------------------------------------------------------
// tb_aes_round_counter
//
// Directed bench for aes_round_counter. Inputs are driven 1 ns after the
// rising edge and outputs are sampled 1 ns after the edge that updates them.
// Expected Rcon values come from the constant AES table below, or are all
// zero when AES_RCON_EN is not defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_round_counter;

  logic clk;
  logic rst_n;

  aes_round_counter_if bus_if ();

  aes_round_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rcon_tab [0:14] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                                  8'h10, 8'h20, 8'h40, 8'h80, 8'h1B,
                                  8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

  function automatic logic [7:0] exp_rcon(input int r);
`ifdef AES_RCON_EN
    return rcon_tab[r];
`else
    return (r >= 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input int rnd, input int rc,
                              input bit busy, input bit done, input bit fin);
    check({tag, " round"},    32'(bus_if.round),    32'(rnd));
    check({tag, " rcon"},     32'(bus_if.rcon),     32'(rc));
    check({tag, " busy"},     32'(bus_if.busy),     32'(busy));
    check({tag, " done"},     32'(bus_if.done),     32'(done));
    check({tag, " is_final"}, 32'(bus_if.is_final), 32'(fin));
  endtask

  // Full sequence with advance held high. key_len is switched to klen_mid
  // right after start to show that Nr is not re-sampled during the run.
  task automatic run_seq(input logic [1:0] klen, input int nr, input logic [1:0] klen_mid);
    string t;
    bus_if.key_len = klen;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start   = 1'b0;
    bus_if.key_len = klen_mid;
    t = $sformatf("k%0b start", klen);
    check_status(t, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    bus_if.advance = 1'b1;
    for (int r = 1; r <= nr; r++) begin
      tick();
      t = $sformatf("k%0b r%0d", klen, r);
      check({t, " round"},    32'(bus_if.round),    32'(r));
      check({t, " rcon"},     32'(bus_if.rcon),     32'(exp_rcon(r)));
      check({t, " is_final"}, 32'(bus_if.is_final), 32'(r == nr));
    end
    tick();
    t = $sformatf("k%0b finish", klen);
    check_status(t, nr, exp_rcon(nr), 1'b0, 1'b1, 1'b0);
    // advance still high while in DONE: ignored
    tick();
    t = $sformatf("k%0b adv_in_done", klen);
    check_status(t, nr, exp_rcon(nr), 1'b0, 1'b1, 1'b0);
    bus_if.advance = 1'b0;
  endtask

  initial begin
    bus_if.start   = 1'b0;
    bus_if.advance = 1'b0;
    bus_if.key_len = 2'b00;
    rst_n          = 1'b0;

    // Reset state
    #12;
    check_status("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // advance in IDLE is ignored
    bus_if.advance = 1'b1;
    tick();
    tick();
    bus_if.advance = 1'b0;
    check_status("adv_in_idle", 0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Full runs for each key length, with key_len disturbed mid-run
    run_seq(2'b00, 10, 2'b10);
    run_seq(2'b01, 12, 2'b00);
    run_seq(2'b10, 14, 2'b01);
    run_seq(2'b11, 10, 2'b10);

    // Restart at round 5 with advance also high: start wins
    bus_if.key_len = 2'b00;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start   = 1'b0;
    bus_if.advance = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_restart round", 32'(bus_if.round), 32'd5);
    bus_if.start = 1'b1;
    tick();
    bus_if.start   = 1'b0;
    bus_if.advance = 1'b0;
    check_status("restart", 0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a run takes effect without a clock edge
    bus_if.start = 1'b1;
    tick();
    bus_if.start   = 1'b0;
    bus_if.advance = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus_if.advance = 1'b0;
    check("pre_reset round", 32'(bus_if.round), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_status("async_reset", 0, 8'h00, 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    tick();
    check_status("post_reset", 0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
